cond_eval_unit: RTL and testbench
=================================

# cond_eval_unit

Condition-evaluation stage directly downstream of the ALU compare/flag stage. Holds the architectural flag register, merges partial flag updates under a mask, and resolves 4-bit condition codes (branch/predication requests) against the current flags. Returns taken/not-taken results with a tag over a valid/ready handshake. Stalls requests while a flag-setting operation is still in flight.

## Interface
- TAG_W, 4, width of request/result tag
- CNT_W, 16, width of the stall-cycle counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flags_in  in  4  new flags from compare stage, bit positions per `ALU_FLAG_Z/N/C/V` in alu_defs.vh
- flags_we  in  1  flag write strobe, one cycle per update
- flags_mask  in  4  per-flag write enable, same bit positions; 0 bits keep the old value
- flags_pend  in  1  a flag-setting op is issued but not yet written
- cc_valid  in  1  request valid
- cc_ready  out  1  request accepted when valid & ready
- cc_code  in  4  condition code
- cc_tag  in  TAG_W  request tag
- res_valid  out  1  result valid
- res_ready  in  1  consumer ready
- res_taken  out  1  condition true
- res_tag  out  TAG_W  tag of the result
- flags_q  out  4  architectural flags
- stall_cnt  out  CNT_W  count of cycles spent in WAIT, wraps

## Operation
- Flag merge: flags_nx = flags_we ? (flags_in & flags_mask) | (flags_q & ~flags_mask) : flags_q. flags_q <= flags_nx every cycle.
- All evaluation uses flags_nx, a same-cycle bypass. A request evaluated in the cycle of a flag write sees the new flags.
- Codes (Z,N,C,V from flags_nx):
  - 0 EQ Z; 1 NE !Z
  - 2 CS C; 3 CC !C
  - 4 MI N; 5 PL !N
  - 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !C|Z
  - 10 GE N==V; 11 LT N!=V
  - 12 GT !Z&(N==V); 13 LE Z|(N!=V)
  - 14 AL 1; 15 NV 0
- FSM with states IDLE, WAIT, HOLD:
  - IDLE: cc_ready=1, res_valid=0.
    - accept & !flags_pend -> evaluate, load res_*, go HOLD.
    - accept & flags_pend -> latch code/tag, go WAIT.
  - WAIT: cc_ready=0, res_valid=0, stall_cnt += 1 each cycle.
    - On the first cycle with flags_pend=0: evaluate the latched request with flags_nx, go HOLD.
  - HOLD: res_valid=1, outputs stable until res_ready. cc_ready = res_ready.
    - res_ready & accept & !flags_pend -> reload res_*, stay HOLD (back-to-back).
    - res_ready & accept & flags_pend -> WAIT.
    - res_ready & !cc_valid -> IDLE.
- Only one request is in flight. There is no queue.

## Timing
- Reset values: flags_q=0, res_valid=0, res_taken=0, res_tag=0, stall_cnt=0, state IDLE, cc_ready=1 after reset release.
- Reset is asynchronous. Assertion mid-operation drops any WAIT/HOLD request and any same-cycle flag write.
- Latency: accept at edge n -> res_valid at n+1 when flags_pend=0.
- WAIT exits on the edge after flags_pend falls. flags_we in that cycle is bypassed.
- Throughput: 1 result/cycle while res_ready=1 and flags_pend=0.
- flags_we in IDLE/WAIT/HOLD always updates flags_q. It never alters a result already held in HOLD.
- stall_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- res_ready is ignored when res_valid=0. cc_valid is ignored when cc_ready=0, and the request must be held by the sender.

## Test plan
- Reset, then flags_we=1, mask=4'hF, Z=1 only; next cycle request EQ tag 3 -> res_valid next cycle, taken=1, tag=3. Then NE -> taken=0.
- Masked write: flags Z=1,C=1, then write mask=C only with C=0 -> flags_q Z=1,C=0. Request HI -> 0, LS -> 1.
- Bypass: flags_we (N=1,V=0) in the same cycle as an LT request -> taken=1. The old flags are not used.
- Pend: flags_pend=1 for 5 cycles around a GE request -> cc_ready=0 and stall_cnt=5. Result is computed with the flags written in the cycle flags_pend drops.
- Backpressure: 3 back-to-back requests (AL, NV, AL), with res_ready low for 2 cycles on the first -> res outputs stable while held; results 1,0,1 in order with correct tags, and no request lost.
- Reset mid-WAIT: rst_n low -> all outputs at reset values, no result emitted; CNT_W=4 forced 17 WAIT cycles -> stall_cnt=1.

Source files
------------

// File: rtl/cond_eval_unit.sv
// Condition-evaluation stage: architectural flag register with masked merge,
// 4-bit condition-code resolution and a single-entry valid/ready result slot.
module cond_eval_unit #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       flags_in,
  input  logic             flags_we,
  input  logic [3:0]       flags_mask,
  input  logic             flags_pend,
  input  logic             cc_valid,
  output logic             cc_ready,
  input  logic [3:0]       cc_code,
  input  logic [TAG_W-1:0] cc_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_taken,
  output logic [TAG_W-1:0] res_tag,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] stall_cnt
);

  // Flag bit positions, matching the ALU compare stage (N Z C V from MSB).
  localparam int unsigned FLAG_V = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_N = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_HOLD} state_t;

  state_t             state_q, state_d;
  logic [3:0]         flags_d;
  logic               res_taken_q, res_taken_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic [3:0]         pcode_q, pcode_d;
  logic [TAG_W-1:0]   ptag_q, ptag_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic               accept;

  // Codes come in complementary pairs: odd code = inverse of the even one.
  function automatic logic cond_eval(input logic [3:0] code, input logic [3:0] f);
    logic base;
    case (code[3:1])
      3'd0:    base = f[FLAG_Z];
      3'd1:    base = f[FLAG_C];
      3'd2:    base = f[FLAG_N];
      3'd3:    base = f[FLAG_V];
      3'd4:    base = f[FLAG_C] & ~f[FLAG_Z];
      3'd5:    base = f[FLAG_N] ~^ f[FLAG_V];
      3'd6:    base = ~f[FLAG_Z] & (f[FLAG_N] ~^ f[FLAG_V]);
      default: base = 1'b1;
    endcase
    return base ^ code[0];
  endfunction

  always_comb begin
    flags_d     = flags_we ? ((flags_in & flags_mask) | (flags_q & ~flags_mask)) : flags_q;
    state_d     = state_q;
    res_taken_d = res_taken_q;
    res_tag_d   = res_tag_q;
    pcode_d     = pcode_q;
    ptag_d      = ptag_q;
    stall_d     = stall_q;
    cc_ready    = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && res_ready);
    res_valid   = (state_q == ST_HOLD);
    accept      = cc_valid & cc_ready;

    case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        stall_d = stall_q + 1'b1;
        if (!flags_pend) begin
          res_taken_d = cond_eval(pcode_q, flags_d);
          res_tag_d   = ptag_q;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: if (res_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // New request from IDLE or from HOLD as the held result drains.
    if (accept) begin
      if (!flags_pend) begin
        res_taken_d = cond_eval(cc_code, flags_d);
        res_tag_d   = cc_tag;
        state_d     = ST_HOLD;
      end else begin
        pcode_d = cc_code;
        ptag_d  = cc_tag;
        state_d = ST_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      flags_q     <= '0;
      res_taken_q <= 1'b0;
      res_tag_q   <= '0;
      pcode_q     <= '0;
      ptag_q      <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      res_taken_q <= res_taken_d;
      res_tag_q   <= res_tag_d;
      pcode_q     <= pcode_d;
      ptag_q      <= ptag_d;
      stall_q     <= stall_d;
    end
  end

  assign res_taken = res_taken_q;
  assign res_tag   = res_tag_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_cond_eval_unit.sv
// Bench for cond_eval_unit: two instances (16- and 4-bit stall counters) share
// stimulus and are checked every cycle against a behavioural model.
module tb_cond_eval_unit;

  localparam logic [3:0] F_V = 4'b0001;
  localparam logic [3:0] F_C = 4'b0010;
  localparam logic [3:0] F_Z = 4'b0100;
  localparam logic [3:0] F_N = 4'b1000;

  logic       clk, rst_n;
  logic [3:0] flags_in, flags_mask, cc_code, cc_tag;
  logic       flags_we, flags_pend, cc_valid, res_ready;

  logic        a_cc_ready, a_res_valid, a_res_taken;
  logic [3:0]  a_res_tag, a_flags_q;
  logic [15:0] a_stall_cnt;
  logic        b_cc_ready, b_res_valid, b_res_taken;
  logic [3:0]  b_res_tag, b_flags_q;
  logic [3:0]  b_stall_cnt;

  cond_eval_unit #(.TAG_W(4), .CNT_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flags_we(flags_we),
    .flags_mask(flags_mask), .flags_pend(flags_pend), .cc_valid(cc_valid),
    .cc_ready(a_cc_ready), .cc_code(cc_code), .cc_tag(cc_tag),
    .res_valid(a_res_valid), .res_ready(res_ready), .res_taken(a_res_taken),
    .res_tag(a_res_tag), .flags_q(a_flags_q), .stall_cnt(a_stall_cnt));

  cond_eval_unit #(.TAG_W(4), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .flags_we(flags_we),
    .flags_mask(flags_mask), .flags_pend(flags_pend), .cc_valid(cc_valid),
    .cc_ready(b_cc_ready), .cc_code(cc_code), .cc_tag(cc_tag),
    .res_valid(b_res_valid), .res_ready(res_ready), .res_taken(b_res_taken),
    .res_tag(b_res_tag), .flags_q(b_flags_q), .stall_cnt(b_stall_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned ncmp = 0;
  int unsigned nfail = 0;

  // Behavioural model: one optional waiting request, one optional held result.
  logic [3:0]  m_flags;
  bit          m_wait, m_held, m_fresh, m_last_acc;
  logic [3:0]  m_wcode, m_wtag, m_tag;
  bit          m_taken;
  int unsigned m_stall;

  function automatic bit cond_true(input logic [3:0] code, input logic [3:0] f);
    bit z, n, c, v;
    z = f[2]; n = f[3]; c = f[1]; v = f[0];
    case (code)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_flags = '0; m_wait = 0; m_held = 0; m_fresh = 1; m_last_acc = 0;
    m_wcode = '0; m_wtag = '0; m_tag = '0; m_taken = 0; m_stall = 0;
  endtask

  task automatic model_update();
    logic [3:0] nx;
    bit rdy, acc, was_wait;
    if (!rst_n) begin
      model_reset();
      return;
    end
    nx = m_flags;
    for (int i = 0; i < 4; i++)
      if (flags_we && flags_mask[i]) nx[i] = flags_in[i];
    rdy = m_held ? res_ready : !m_wait;
    acc = cc_valid && rdy;
    m_last_acc = acc;
    was_wait = m_wait;
    if (m_held && res_ready) m_held = 0;
    if (was_wait) begin
      m_stall++;
      if (!flags_pend) begin
        m_wait = 0; m_held = 1; m_fresh = 0;
        m_taken = cond_true(m_wcode, nx); m_tag = m_wtag;
      end
    end else if (acc) begin
      if (!flags_pend) begin
        m_held = 1; m_fresh = 0;
        m_taken = cond_true(cc_code, nx); m_tag = cc_tag;
      end else begin
        m_wait = 1; m_wcode = cc_code; m_wtag = cc_tag;
      end
    end
    m_flags = nx;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    bit exp_ready;
    exp_ready = m_held ? res_ready : !m_wait;
    cmp("cc_ready16", a_cc_ready, exp_ready);
    cmp("cc_ready4", b_cc_ready, exp_ready);
    cmp("res_valid16", a_res_valid, m_held);
    cmp("res_valid4", b_res_valid, m_held);
    cmp("flags_q16", a_flags_q, m_flags);
    cmp("flags_q4", b_flags_q, m_flags);
    cmp("stall16", a_stall_cnt, m_stall & 32'hFFFF);
    cmp("stall4", b_stall_cnt, m_stall & 32'hF);
    if (m_held || m_fresh) begin
      cmp("res_taken16", a_res_taken, m_taken);
      cmp("res_taken4", b_res_taken, m_taken);
      cmp("res_tag16", a_res_tag, m_tag);
      cmp("res_tag4", b_res_tag, m_tag);
    end
  endtask

  // Inputs are set at the falling edge; one call spans one clock cycle.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic expect_res(input string name, input bit taken, input logic [3:0] tag);
    cmp({name, "_valid"}, a_res_valid, 1'b1);
    cmp({name, "_taken"}, a_res_taken, taken);
    cmp({name, "_tag"}, a_res_tag, tag);
  endtask

  initial begin
    rst_n = 0; flags_in = '0; flags_mask = '0; flags_we = 0; flags_pend = 0;
    cc_valid = 0; cc_code = '0; cc_tag = '0; res_ready = 1;
    model_reset();
    @(negedge clk);
    step(); step();
    cmp("rst_valid", a_res_valid, 1'b0);
    cmp("rst_flags", a_flags_q, 4'h0);
    cmp("rst_stall", a_stall_cnt, 16'h0);
    cmp("rst_tag", a_res_tag, 4'h0);
    rst_n = 1;
    step();
    cmp("rst_ready", a_cc_ready, 1'b1);

    // Z only, then EQ / NE back-to-back
    flags_we = 1; flags_mask = 4'hF; flags_in = F_Z; step(); flags_we = 0;
    cmp("z_write", a_flags_q, F_Z);
    cc_valid = 1; cc_code = 4'd0; cc_tag = 4'd3; step();
    expect_res("eq", 1'b1, 4'd3);
    cc_code = 4'd1; cc_tag = 4'd4; step();
    expect_res("ne", 1'b0, 4'd4);
    cc_valid = 0; step();
    cmp("idle_valid", a_res_valid, 1'b0);

    // Masked write: Z,C set then clear C only
    flags_we = 1; flags_mask = 4'hF; flags_in = F_Z | F_C; step();
    flags_mask = F_C; flags_in = 4'h0; step(); flags_we = 0;
    cmp("mask_write", a_flags_q, F_Z);
    cc_valid = 1; cc_code = 4'd8; cc_tag = 4'd5; step();
    expect_res("hi", 1'b0, 4'd5);
    cc_code = 4'd9; cc_tag = 4'd6; step();
    expect_res("ls", 1'b1, 4'd6);
    cc_valid = 0; step();

    // Bypass: LT in the cycle N=1 is written
    flags_we = 1; flags_mask = 4'hF; flags_in = F_N;
    cc_valid = 1; cc_code = 4'd11; cc_tag = 4'd7; step();
    flags_we = 0; cc_valid = 0;
    expect_res("lt_bypass", 1'b1, 4'd7);
    step();

    // Pend: GE accepted while pending, flags cleared as pend drops
    flags_pend = 1; cc_valid = 1; cc_code = 4'd10; cc_tag = 4'd8; step();
    cc_valid = 0;
    repeat (4) begin
      step();
      cmp("wait_ready", a_cc_ready, 1'b0);
      cmp("wait_valid", a_res_valid, 1'b0);
    end
    flags_pend = 0; flags_we = 1; flags_mask = 4'hF; flags_in = 4'h0; step();
    flags_we = 0;
    expect_res("ge_pend", 1'b1, 4'd8);
    cmp("pend_stall16", a_stall_cnt, 16'd5);
    cmp("pend_stall4", b_stall_cnt, 4'd5);
    step();

    // Backpressure: AL, NV, AL with res_ready low for 2 cycles on the first
    cc_valid = 1; cc_code = 4'd14; cc_tag = 4'd9; step();
    res_ready = 0; cc_code = 4'd15; cc_tag = 4'd10;
    repeat (2) begin
      step();
      expect_res("bp_hold", 1'b1, 4'd9);
      cmp("bp_ready", a_cc_ready, 1'b0);
    end
    res_ready = 1; step();
    expect_res("bp_nv", 1'b0, 4'd10);
    cc_code = 4'd14; cc_tag = 4'd11; step();
    expect_res("bp_al", 1'b1, 4'd11);
    cc_valid = 0; step();
    cmp("bp_drain", a_res_valid, 1'b0);

    // Reset in WAIT, then 17 WAIT cycles wrap the 4-bit counter to 1
    flags_pend = 1; cc_valid = 1; cc_code = 4'd10; cc_tag = 4'd12; step();
    cc_valid = 0; step(); step();
    rst_n = 0; model_reset();
    #1;
    cmp("arst_valid", a_res_valid, 1'b0);
    cmp("arst_ready", a_cc_ready, 1'b1);
    cmp("arst_stall", a_stall_cnt, 16'h0);
    cmp("arst_flags", a_flags_q, 4'h0);
    step();
    rst_n = 1; step();
    cmp("arst_noresult", a_res_valid, 1'b0);
    cc_valid = 1; cc_code = 4'd14; cc_tag = 4'd13; step();
    cc_valid = 0;
    repeat (16) step();
    flags_pend = 0; step();
    cmp("wrap_stall4", b_stall_cnt, 4'd1);
    cmp("wrap_stall16", a_stall_cnt, 16'd17);
    expect_res("wrap_res", 1'b1, 4'd13);
    step();

    // Randomized traffic; a pending request is held until accepted
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0; cc_valid = 0; model_reset();
      end else begin
        rst_n = 1;
        if (!(cc_valid && !m_last_acc)) begin
          cc_valid = ($urandom_range(0, 2) != 0);
          cc_code = 4'($urandom);
          cc_tag = 4'($urandom);
        end
      end
      flags_we = ($urandom_range(0, 2) == 0);
      flags_in = 4'($urandom);
      flags_mask = 4'($urandom);
      if ($urandom_range(0, 3) == 0) flags_pend = !flags_pend;
      res_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nfail);
    $finish;
  end

endmodule
